// File: rtl/alu_md_if.sv
// ---------------------------------------------------------------------------
// alu_md_if
//   Handshake/bus bundle between the execute stage and the alu_md block.
//   master : drives the op request (flush, in_valid, op, a, b) and out_ready.
//   slave  : the ALU; drives in_ready, out_valid, result, eq and busy.
//   Signals:
//     flush      sync abort of any op in flight
//     in_valid   op/a/b valid          in_ready   ALU can accept this cycle
//     op[4:0]    operation select      a, b       operands (rs1, rs2/imm)
//     out_valid  result/eq valid       out_ready  consumer takes result
//     result     operation result      eq         result == 0
//     busy       iterative op in progress
// ---------------------------------------------------------------------------
interface alu_md_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             eq;
    logic             busy;

    modport master (
        output flush, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, eq, busy
    );

    modport slave (
        input  flush, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, eq, busy
    );
endinterface

// File: rtl/alu_md.sv
// ---------------------------------------------------------------------------
// alu_md
//   Execute-stage ALU with the RV32M multiply/divide extension.
//   Base ops complete in one cycle; MUL*/DIV*/REM* iterate one bit per
//   cycle (WIDTH steps). Divide-by-zero and signed overflow take the
//   single-cycle path. Result and eq are registered and held until the
//   consumer takes them (out_valid & out_ready).
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   alu_md_if slave: flush, in_valid/in_ready, op, a, b,
//           out_valid/out_ready, result, eq, busy
// ---------------------------------------------------------------------------
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_md_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [SW-1:0]    count;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] result_q;
    logic             eq_q;

    // Iterative datapath: acc holds {product} for multiply, {remainder,
    // quotient} for divide; md is the multiplicand or divisor magnitude.
    logic [2:0]       op_q;
    logic             sa_q;   // sign of a (remainder sign)
    logic             sx_q;   // product/quotient negated
    logic [WIDTH-1:0] md_q;
    logic [W2-1:0]    acc_q;

    logic             accept;
    logic             xfer;
    logic             is_iter;
    logic             is_div;
    logic             div0;
    logic             ovf;
    logic             fast;
    logic [WIDTH-1:0] fast_res;
    logic             a_sgn;
    logic             b_sgn;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [W2-1:0]    step_nxt;
    logic [WIDTH-1:0] fin_res;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] alu_base(input logic [4:0]       f,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0]        r;
        logic signed [WIDTH-1:0] xs;
        logic signed [WIDTH-1:0] ys;
        logic [SW-1:0]           sh;
        xs = x;
        ys = y;
        sh = y[SW-1:0];
        case (f)
            5'b00000: r = x + y;
            5'b00001: r = x - y;
            5'b00010: r = x & y;
            5'b00011: r = x | y;
            5'b00100: r = x ^ y;
            5'b00101: r = x << sh;
            5'b00110: r = x >> sh;
            5'b01001: r = xs >>> sh;
            5'b00111: r = {{(WIDTH-1){1'b0}}, x < y};
            5'b01010: r = {{(WIDTH-1){1'b0}}, xs < ys};
            5'b01000: r = y;
            default:  r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] neg_fix(input logic [WIDTH-1:0] v,
                                                 input logic             n);
        return n ? -v : v;
    endfunction

    function automatic logic [W2-1:0] neg_fix2(input logic [W2-1:0] v,
                                               input logic          n);
        return n ? -v : v;
    endfunction

    assign accept = bus.in_valid & bus.in_ready & ~bus.flush;
    assign xfer   = out_valid_q & bus.out_ready;

    assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = result_q;
    assign bus.eq        = eq_q;

    // Decode of the incoming op; op[0]=0 marks the signed divide forms.
    assign is_iter = (bus.op[4:3] == 2'b10);
    assign is_div  = is_iter & bus.op[2];
    assign div0    = is_div & (bus.b == '0);
    assign ovf     = is_div & ~bus.op[0] & (bus.a == MIN_NEG) & (bus.b == '1);
    assign fast    = ~is_iter | div0 | ovf;

    always_comb begin
        fast_res = '0;
        if (!is_iter)
            fast_res = alu_base(bus.op, bus.a, bus.b);
        else if (div0)
            fast_res = bus.op[1] ? bus.a : '1;
        else if (ovf)
            fast_res = bus.op[1] ? '0 : MIN_NEG;
    end

    // MULHSU treats b as unsigned, MULHU both; DIVU/REMU both unsigned.
    always_comb begin
        if (bus.op[2]) begin
            a_sgn = ~bus.op[0] & bus.a[WIDTH-1];
            b_sgn = ~bus.op[0] & bus.b[WIDTH-1];
        end else begin
            a_sgn = (bus.op[1:0] != 2'b11) & bus.a[WIDTH-1];
            b_sgn = ~bus.op[1] & bus.b[WIDTH-1];
        end
        a_mag = neg_fix(bus.a, a_sgn);
        b_mag = neg_fix(bus.b, b_sgn);
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        logic [WIDTH:0] sum;
        logic [WIDTH:0] r_sh;
        logic [WIDTH:0] diff;
        sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? md_q : '0)};
        r_sh = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        diff = r_sh - {1'b0, md_q};
        if (!op_q[2])
            step_nxt = {sum, acc_q[WIDTH-1:1]};
        else if (!diff[WIDTH])
            step_nxt = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        else
            step_nxt = {r_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    always_comb begin
        logic [W2-1:0] prod;
        prod = neg_fix2(step_nxt, sx_q);
        if (op_q[2])
            fin_res = op_q[1] ? neg_fix(step_nxt[W2-1:WIDTH], sa_q)
                              : neg_fix(step_nxt[WIDTH-1:0], sx_q);
        else
            fin_res = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[W2-1:WIDTH];
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            eq_q        <= 1'b1;
        end else if (bus.flush) begin
            state       <= IDLE;
            count       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        count <= '0;
                        if (fast) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            busy_q      <= 1'b0;
                            result_q    <= fast_res;
                            eq_q        <= (fast_res == '0);
                        end else begin
                            state       <= CALC;
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end else if (state == DONE && xfer) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                CALC: begin
                    if (count == SW'(WIDTH - 1)) begin
                        state       <= DONE;
                        count       <= '0;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        result_q    <= fin_res;
                        eq_q        <= (fin_res == '0);
                    end else begin
                        count <= count + SW'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    count       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Operand capture and iteration registers; reloaded on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= bus.op[2:0];
            sa_q <= a_sgn;
            sx_q <= a_sgn ^ b_sgn;
            if (bus.op[2]) begin
                md_q  <= b_mag;
                acc_q <= {{WIDTH{1'b0}}, a_mag};
            end else begin
                md_q  <= a_mag;
                acc_q <= {{WIDTH{1'b0}}, b_mag};
            end
        end else if (state == CALC) begin
            acc_q <= step_nxt;
        end
    end
endmodule
